// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared types and encodings for the multicycle control FSM
package mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_EXECR  = 4'd2,
      S_EXECI  = 4'd3,
      S_ALUWB  = 4'd4,
      S_MEMADR = 4'd5,
      S_MEMRD  = 4'd6,
      S_MEMWB  = 4'd7,
      S_MEMWR  = 4'd8,
      S_BRANCH = 4'd9,
      S_LINK   = 4'd10,
      S_UNDEF  = 4'd11,
      S_FAULT  = 4'd12
   } state_e;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALURES = 2'b10;
   localparam logic [1:0] RES_PC     = 2'b11;

   localparam logic [1:0] SRCA_RD1   = 2'b00;
   localparam logic [1:0] SRCA_PC    = 2'b01;
   localparam logic [1:0] SRCA_OLDPC = 2'b10;

   localparam logic [1:0] SRCB_RD2   = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;

   localparam logic [1:0] OP_DP      = 2'b00;
   localparam logic [1:0] OP_MEM     = 2'b01;
   localparam logic [1:0] OP_BR      = 2'b10;
   localparam logic [1:0] OP_UNDEF   = 2'b11;

   // States that sit on the memory handshake and are guarded by the timeout.
   function automatic logic is_wait_state(input state_e s);
      return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
   endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// rtl/mc_wait_timer.sv - memory wait-state counter with timeout compare
module mc_wait_timer #(
   parameter int TIMEOUT = 16
) (
   input  logic clk_i,
   input  logic resetn_i,
   input  logic wait_i,
   input  logic ready_i,
   output logic expired
);

   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

   logic [CW-1:0] cnt_q, cnt_d;

   // Any cycle outside a waiting hold clears, so every entry starts from zero.
   always_comb begin
      cnt_d = cnt_q;
      if (!wait_i || ready_i || (TIMEOUT == 0)) begin
         cnt_d = '0;
      end else if (cnt_q != LIMIT) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!resetn_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (TIMEOUT != 0) && wait_i && !ready_i && (cnt_q == LIMIT);

endmodule

// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - main control FSM of the multicycle ARM-subset core
module mc_ctrl_fsm
   import mc_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int HAS_BL  = 1,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       Op,
   input  logic [5:0]       Funct,
   input  logic             Link,
   input  logic             MemReady,
   output logic             MemReq,
   output logic             NextPC,
   output logic             Branch,
   output logic             MemW,
   output logic             RegW,
   output logic             IRWrite,
   output logic             AdrSrc,
   output logic             ALUOp,
   output logic [1:0]       ResultSrc,
   output logic [1:0]       ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic             LinkWr,
   output logic             Undef,
   output logic             Fault,
   output logic             Retired,
   output logic [CNT_W-1:0] RetireCount
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             waiting;
   logic             expired;
   logic             unused_funct;

   assign unused_funct = ^Funct[4:1];
   assign waiting      = is_wait_state(state_q);

   mc_wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_wait_timer (
      .clk_i    (clk),
      .resetn_i (reset),
      .wait_i   (waiting),
      .ready_i  (MemReady),
      .expired  (expired)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_FETCH;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH: begin
            if (expired)       state_d = S_FAULT;
            else if (MemReady) state_d = S_DECODE;
         end
         S_DECODE: begin
            case (Op)
               OP_DP:    state_d = Funct[5] ? S_EXECI : S_EXECR;
               OP_MEM:   state_d = S_MEMADR;
               OP_BR:    state_d = ((HAS_BL != 0) && Link) ? S_LINK : S_BRANCH;
               OP_UNDEF: state_d = S_UNDEF;
               default:  state_d = S_UNDEF;
            endcase
         end
         S_EXECR, S_EXECI: state_d = S_ALUWB;
         S_MEMADR:         state_d = Funct[0] ? S_MEMRD : S_MEMWR;
         S_MEMRD: begin
            if (expired)       state_d = S_FAULT;
            else if (MemReady) state_d = S_MEMWB;
         end
         S_MEMWR: begin
            if (expired)       state_d = S_FAULT;
            else if (MemReady) state_d = S_FETCH;
         end
         S_LINK:           state_d = S_BRANCH;
         S_ALUWB, S_MEMWB, S_BRANCH, S_UNDEF: state_d = S_FETCH;
         S_FAULT:          state_d = S_FAULT;
         default:          state_d = S_FETCH;
      endcase
   end

   // Moore decode; only FETCH's IRWrite/NextPC and MEMWR's retire look at MemReady.
   always_comb begin
      MemReq    = 1'b0;
      NextPC    = 1'b0;
      Branch    = 1'b0;
      MemW      = 1'b0;
      RegW      = 1'b0;
      IRWrite   = 1'b0;
      AdrSrc    = 1'b0;
      ALUOp     = 1'b0;
      ResultSrc = RES_ALUOUT;
      ALUSrcA   = SRCA_RD1;
      ALUSrcB   = SRCB_RD2;
      LinkWr    = 1'b0;
      Undef     = 1'b0;
      Fault     = 1'b0;
      Retired   = 1'b0;
      case (state_q)
         S_FETCH: begin
            MemReq    = 1'b1;
            IRWrite   = MemReady;
            NextPC    = MemReady;
            ResultSrc = RES_ALURES;
            ALUSrcA   = SRCA_PC;
            ALUSrcB   = SRCB_FOUR;
         end
         S_DECODE: begin
            ResultSrc = RES_ALURES;
            ALUSrcA   = SRCA_PC;
            ALUSrcB   = SRCB_FOUR;
         end
         S_EXECR: ALUOp = 1'b1;
         S_EXECI: begin
            ALUSrcB = SRCB_IMM;
            ALUOp   = 1'b1;
         end
         S_ALUWB: begin
            RegW    = 1'b1;
            Retired = 1'b1;
         end
         S_MEMADR: ALUSrcB = SRCB_IMM;
         S_MEMRD: begin
            MemReq = 1'b1;
            AdrSrc = 1'b1;
         end
         S_MEMWR: begin
            MemReq  = 1'b1;
            AdrSrc  = 1'b1;
            MemW    = 1'b1;
            Retired = MemReady;
         end
         S_MEMWB: begin
            RegW      = 1'b1;
            ResultSrc = RES_DATA;
            Retired   = 1'b1;
         end
         S_LINK: begin
            RegW      = 1'b1;
            LinkWr    = 1'b1;
            ResultSrc = RES_PC;
         end
         S_BRANCH: begin
            Branch    = 1'b1;
            ResultSrc = RES_ALURES;
            ALUSrcA   = SRCA_OLDPC;
            ALUSrcB   = SRCB_IMM;
            Retired   = 1'b1;
         end
         S_UNDEF: Undef = 1'b1;
         S_FAULT: Fault = 1'b1;
         default: ;
      endcase
   end

   assign count_d     = Retired ? count_q + 1'b1 : count_q;
   assign RetireCount = count_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb/tb_mc_ctrl_fsm.sv - self-checking bench for mc_ctrl_fsm
module tb_mc_ctrl_fsm;

   localparam int TO = 4;
   localparam int CW = 4;

   localparam int PH_FETCH = 0, PH_DECODE = 1, PH_EXECR = 2, PH_EXECI = 3,
                  PH_ALUWB = 4, PH_MEMADR = 5, PH_MEMRD = 6, PH_MEMWB = 7,
                  PH_MEMWR = 8, PH_BRANCH = 9, PH_LINK = 10, PH_UNDEF = 11,
                  PH_FAULT = 12;

   typedef struct packed {
      logic       memreq, nextpc, branch, memw, regw, irwrite, adrsrc, aluop;
      logic [1:0] res, srca, srcb;
      logic       linkwr, undef, fault, retired;
   } outv_t;

   typedef struct {
      int ph;
      bit mr;
   } ent_t;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [1:0]    Op = 2'b00;
   logic [5:0]    Funct = 6'b0;
   logic          Link = 1'b0;
   logic          MemReady = 1'b0;
   logic          MemReq, NextPC, Branch, MemW, RegW, IRWrite, AdrSrc, ALUOp;
   logic [1:0]    ResultSrc, ALUSrcA, ALUSrcB;
   logic          LinkWr, Undef, Fault, Retired;
   logic [CW-1:0] RetireCount;

   ent_t          q[$];
   int            checks = 0;
   int            errors = 0;
   logic [CW-1:0] model_cnt = '0;
   int            irw_seen = 0;
   int            undef_seen = 0;

   mc_ctrl_fsm #(.TIMEOUT(TO), .HAS_BL(1), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Link(Link),
      .MemReady(MemReady), .MemReq(MemReq), .NextPC(NextPC), .Branch(Branch),
      .MemW(MemW), .RegW(RegW), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
      .ALUOp(ALUOp), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .LinkWr(LinkWr), .Undef(Undef), .Fault(Fault),
      .Retired(Retired), .RetireCount(RetireCount)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic outv_t exp_out(input int ph, input bit mr);
      outv_t o;
      o = '0;
      case (ph)
         PH_FETCH:  begin o.memreq = 1; o.irwrite = mr; o.nextpc = mr;
                          o.res = 2'b10; o.srca = 2'b01; o.srcb = 2'b10; end
         PH_DECODE: begin o.res = 2'b10; o.srca = 2'b01; o.srcb = 2'b10; end
         PH_EXECR:  o.aluop = 1;
         PH_EXECI:  begin o.srcb = 2'b01; o.aluop = 1; end
         PH_ALUWB:  begin o.regw = 1; o.retired = 1; end
         PH_MEMADR: o.srcb = 2'b01;
         PH_MEMRD:  begin o.memreq = 1; o.adrsrc = 1; end
         PH_MEMWR:  begin o.memreq = 1; o.adrsrc = 1; o.memw = 1; o.retired = mr; end
         PH_MEMWB:  begin o.regw = 1; o.res = 2'b01; o.retired = 1; end
         PH_LINK:   begin o.regw = 1; o.linkwr = 1; o.res = 2'b11; end
         PH_BRANCH: begin o.branch = 1; o.res = 2'b10; o.srca = 2'b10;
                          o.srcb = 2'b01; o.retired = 1; end
         PH_UNDEF:  o.undef = 1;
         PH_FAULT:  o.fault = 1;
         default:   o = '0;
      endcase
      return o;
   endfunction

   task automatic push(input int ph, input bit mr);
      ent_t e;
      e.ph = ph;
      e.mr = mr;
      q.push_back(e);
   endtask

   // Expected per-cycle phase list of one instruction from its class and wait counts.
   task automatic build(input logic [1:0] op, input logic [5:0] funct, input logic link,
                        input int fw, input int mw);
      for (int i = 0; i < fw; i++) push(PH_FETCH, 0);
      push(PH_FETCH, 1);
      push(PH_DECODE, 1);
      case (op)
         2'b00: begin
            push(funct[5] ? PH_EXECI : PH_EXECR, 1);
            push(PH_ALUWB, 1);
         end
         2'b01: begin
            push(PH_MEMADR, 1);
            if (funct[0]) begin
               for (int i = 0; i < mw; i++) push(PH_MEMRD, 0);
               push(PH_MEMRD, 1);
               push(PH_MEMWB, 1);
            end else begin
               for (int i = 0; i < mw; i++) push(PH_MEMWR, 0);
               push(PH_MEMWR, 1);
            end
         end
         2'b10: begin
            if (link) push(PH_LINK, 1);
            push(PH_BRANCH, 1);
         end
         default: push(PH_UNDEF, 1);
      endcase
   endtask

   task automatic cycle_check(input ent_t e);
      outv_t act, exp;
      exp = exp_out(e.ph, e.mr);
      act = {MemReq, NextPC, Branch, MemW, RegW, IRWrite, AdrSrc, ALUOp,
             ResultSrc, ALUSrcA, ALUSrcB, LinkWr, Undef, Fault, Retired};
      chk($sformatf("outputs_ph%0d", e.ph), 32'(act), 32'(exp));
      chk("retire_count", 32'(RetireCount), 32'(model_cnt));
      if (IRWrite === 1'b1) irw_seen++;
      if (Undef === 1'b1) undef_seen++;
      if (exp.retired) model_cnt++;
   endtask

   task automatic run(input int limit);
      ent_t e;
      int   n;
      n = 0;
      while (q.size() > 0 && (limit == 0 || n < limit)) begin
         e = q.pop_front();
         MemReady = e.mr;
         @(negedge clk);
         cycle_check(e);
         @(posedge clk);
         #1;
         n++;
      end
      q.delete();
   endtask

   task automatic instr(input logic [1:0] op, input logic [5:0] funct, input logic link,
                        input int fw, input int mw, input int exp_len, input int limit);
      Op = op;
      Funct = funct;
      Link = link;
      build(op, funct, link, fw, mw);
      chk("seq_len", q.size(), exp_len);
      run(limit);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      MemReady = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      model_cnt = '0;
      @(negedge clk);
      chk("rst_fault", 32'(Fault), 0);
      chk("rst_memreq", 32'(MemReq), 1);
      chk("rst_irwrite", 32'(IRWrite), 0);
      chk("rst_count", 32'(RetireCount), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int irw0, und0;
      @(posedge clk);
      do_reset();

      instr(2'b00, 6'b000100, 1'b0, 0, 0, 4, 0);
      chk("add_count", 32'(RetireCount), 1);

      irw0 = irw_seen;
      instr(2'b01, 6'b011001, 1'b0, 0, 3, 8, 0);
      chk("ldr_irwrite_once", irw_seen - irw0, 1);
      chk("ldr_count", 32'(RetireCount), 2);

      instr(2'b01, 6'b000000, 1'b0, 0, 0, 4, 0);
      instr(2'b01, 6'b000000, 1'b0, 1, 2, 7, 0);
      instr(2'b00, 6'b100000, 1'b0, 2, 0, 6, 0);
      instr(2'b10, 6'b000000, 1'b0, 0, 0, 3, 0);
      instr(2'b10, 6'b000000, 1'b1, 0, 0, 4, 0);
      instr(2'b01, 6'b011001, 1'b0, 0, 0, 5, 0);
      chk("mix_count", 32'(RetireCount), 8);

      und0 = undef_seen;
      instr(2'b11, 6'b000000, 1'b0, 0, 0, 3, 0);
      chk("undef_pulse", undef_seen - und0, 1);
      chk("undef_count", 32'(RetireCount), 8);

      instr(2'b00, 6'b000100, 1'b0, 0, 0, 4, 3);
      do_reset();
      instr(2'b00, 6'b000100, 1'b0, 0, 0, 4, 0);
      chk("post_reset_count", 32'(RetireCount), 1);

      do_reset();
      repeat (15) instr(2'b10, 6'b000000, 1'b0, 0, 0, 3, 0);
      chk("wrap_15", 32'(RetireCount), 15);
      instr(2'b10, 6'b000000, 1'b0, 0, 0, 3, 0);
      chk("wrap_0", 32'(RetireCount), 0);

      Op = 2'b00;
      for (int i = 0; i < TO + 1; i++) push(PH_FETCH, 0);
      for (int i = 0; i < 3; i++) push(PH_FAULT, 0);
      for (int i = 0; i < 2; i++) push(PH_FAULT, 1);
      run(0);
      chk("fault_sticky", 32'(Fault), 1);
      chk("fault_memreq", 32'(MemReq), 0);

      do_reset();
      instr(2'b00, 6'b000100, 1'b0, 0, 0, 4, 0);
      chk("after_fault_count", 32'(RetireCount), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
